display_scanner: RTL and testbench

//  Time-multiplexed anode scanner for the 4-digit seven-segment display: owns refresh timing.

---
 rtl/display_scanner_if.sv | 24 ++
 rtl/display_scanner.sv | 154 +++++++++++++++
 tb/tb_display_scanner.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/display_scanner_if.sv
// Load channel for display_scanner: one display word per valid/ready transfer.
interface display_scanner_if;
    logic       load_valid;
    logic       load_ready;
    logic [5:0] value_in;
    logic       negative_in;
    logic       is_dec_in;

    modport master (
        output load_valid,
        output value_in,
        output negative_in,
        output is_dec_in,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  value_in,
        input  negative_in,
        input  is_dec_in,
        output load_ready
    );
endinterface

// File: rtl/display_scanner.sv
// Four-digit seven-segment anode scanner with blanking gap and frame-aligned,
// tear-free commit of display words accepted over a valid/ready channel.
module display_scanner #(
    parameter int DIGIT_TICKS = 100_000,
    parameter int BLANK_TICKS = 1_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    display_scanner_if.slave    load_bus,
    output logic [3:0]          digit,
    output logic [5:0]          display_value,
    output logic                show_negative,
    output logic                is_dec,
    output logic                frame_done
);

    localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int CW        = $clog2(MAX_TICKS + 1);
    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_TICKS - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        BLANK
    } state_t;

    state_t        state, state_n;
    logic [1:0]    idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    digit_n;
    logic          wrap;

    logic          pend_full, pend_full_n;
    logic [5:0]    pend_value;
    logic          pend_negative;
    logic          pend_dec;
    logic          load_ready_q;
    logic          accept;
    logic          commit;

    assign load_bus.load_ready = load_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        wrap    = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            idx_n   = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = SHOW;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
                SHOW: begin
                    if (cnt == DIGIT_LAST) begin
                        cnt_n = '0;
                        if (BLANK_TICKS > 0) begin
                            state_n = BLANK;
                        end else begin
                            idx_n = idx + 2'd1;
                            wrap  = (idx == 2'd3);
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_n = SHOW;
                        cnt_n   = '0;
                        idx_n   = idx + 2'd1;
                        wrap    = (idx == 2'd3);
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
            endcase
        end

        // Anodes are decoded from the next state so the registered output lines up with it.
        digit_n = 4'b1111;
        if (state_n == SHOW) begin
            digit_n = ~(4'b0001 << idx_n);
        end
    end

    // A word accepted on the boundary edge sees pend_full=0 there, so it waits a full frame.
    assign accept = load_bus.load_valid && load_ready_q;
    assign commit = pend_full && ((state == IDLE) || wrap);

    always_comb begin
        pend_full_n = pend_full;
        if (accept) begin
            pend_full_n = 1'b1;
        end else if (commit) begin
            pend_full_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit         <= 4'b1111;
            frame_done    <= 1'b0;
            pend_full     <= 1'b0;
            pend_value    <= '0;
            pend_negative <= 1'b0;
            pend_dec      <= 1'b0;
            load_ready_q  <= 1'b1;
            display_value <= '0;
            show_negative <= 1'b0;
            is_dec        <= 1'b0;
        end else begin
            digit        <= digit_n;
            frame_done   <= wrap;
            pend_full    <= pend_full_n;
            load_ready_q <= ~pend_full_n;
            if (accept) begin
                pend_value    <= load_bus.value_in;
                pend_negative <= load_bus.negative_in;
                pend_dec      <= load_bus.is_dec_in;
            end
            if (commit) begin
                display_value <= pend_value;
                show_negative <= pend_negative;
                is_dec        <= pend_dec;
            end
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner: scan timing, load commit, disable, no-blank variant, reset.
module tb_display_scanner;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic en0;

    always #5 clk = ~clk;

    display_scanner_if ld();
    display_scanner_if ld0();

    logic [3:0] digit, digit0;
    logic [5:0] dv, dv0;
    logic       neg, neg0, dec, dec0, fd, fd0;

    int total = 0;
    int bad   = 0;

    display_scanner #(.DIGIT_TICKS(4), .BLANK_TICKS(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .load_bus      (ld.slave),
        .digit         (digit),
        .display_value (dv),
        .show_negative (neg),
        .is_dec        (dec),
        .frame_done    (fd)
    );

    display_scanner #(.DIGIT_TICKS(4), .BLANK_TICKS(0)) dut0 (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (en0),
        .load_bus      (ld0.slave),
        .digit         (digit0),
        .display_value (dv0),
        .show_negative (neg0),
        .is_dec        (dec0),
        .frame_done    (fd0)
    );

    function automatic logic [3:0] sel(input int unsigned i);
        logic [1:0] i2;
        i2 = i[1:0];
        return 4'b1111 ^ (4'b0001 << i2);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        en0 = 1'b0;
        ld.load_valid = 1'b0;  ld.value_in = '0;  ld.negative_in = 1'b0;  ld.is_dec_in = 1'b0;
        ld0.load_valid = 1'b0; ld0.value_in = '0; ld0.negative_in = 1'b0; ld0.is_dec_in = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        total++; if (digit !== 4'b1111) begin bad++; $display("FAIL reset_digit got=%b want=1111", digit); end
        total++; if (dv !== 6'd0) begin bad++; $display("FAIL reset_value got=%0d want=0", dv); end
        total++; if (neg !== 1'b0) begin bad++; $display("FAIL reset_neg got=%b want=0", neg); end
        total++; if (dec !== 1'b0) begin bad++; $display("FAIL reset_dec got=%b want=0", dec); end
        total++; if (ld.load_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ld.load_ready); end
        total++; if (fd !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", fd); end
        total++; if (digit0 !== 4'b1111) begin bad++; $display("FAIL reset_digit0 got=%b want=1111", digit0); end
    endtask

    task automatic test_scan();
        logic [3:0] exp_d;
        logic       exp_fd;
        int unsigned pos;
        enable = 1'b1;
        for (int unsigned k = 0; k <= 48; k++) begin
            step();
            pos    = k % 24;
            exp_d  = ((pos % 6) < 4) ? sel(pos / 6) : 4'b1111;
            exp_fd = (k == 24) || (k == 48);
            total++; if (digit !== exp_d) begin bad++; $display("FAIL scan_digit k=%0d got=%b want=%b", k, digit, exp_d); end
            total++; if (fd !== exp_fd) begin bad++; $display("FAIL scan_frame_done k=%0d got=%b want=%b", k, fd, exp_fd); end
        end
        enable = 1'b0;
        step();
        step();
    endtask

    task automatic test_idle_load();
        ld.value_in = 6'd42; ld.negative_in = 1'b1; ld.is_dec_in = 1'b1; ld.load_valid = 1'b1;
        step();
        ld.load_valid = 1'b0;
        total++; if (ld.load_ready !== 1'b0) begin bad++; $display("FAIL idle_ready_busy got=%b want=0", ld.load_ready); end
        total++; if (dv !== 6'd0) begin bad++; $display("FAIL idle_value_before got=%0d want=0", dv); end
        step();
        total++; if (dv !== 6'd42) begin bad++; $display("FAIL idle_value got=%0d want=42", dv); end
        total++; if (neg !== 1'b1) begin bad++; $display("FAIL idle_neg got=%b want=1", neg); end
        total++; if (dec !== 1'b1) begin bad++; $display("FAIL idle_dec got=%b want=1", dec); end
        for (int unsigned k = 0; k < 4; k++) begin
            total++; if (ld.load_ready !== 1'b1) begin bad++; $display("FAIL idle_ready k=%0d got=%b want=1", k, ld.load_ready); end
            total++; if (dv !== 6'd42) begin bad++; $display("FAIL idle_hold k=%0d got=%0d want=42", k, dv); end
            step();
        end
    endtask

    task automatic test_frame_commit();
        logic [5:0] exp_dv;
        logic       exp_neg, exp_dec, exp_rdy, exp_fd;
        enable = 1'b1;
        for (int unsigned k = 0; k <= 49; k++) begin
            step();
            exp_dv  = (k < 24) ? 6'd42 : (k < 48) ? 6'd17 : 6'd5;
            exp_neg = (k < 24) ? 1'b1 : (k < 48) ? 1'b0 : 1'b1;
            exp_dec = (k < 24);
            exp_rdy = (k < 8) ? 1'b1 : (k < 24) ? 1'b0 : (k == 24) ? 1'b1 : (k < 48) ? 1'b0 : 1'b1;
            exp_fd  = (k == 24) || (k == 48);
            total++; if (dv !== exp_dv) begin bad++; $display("FAIL commit_value k=%0d got=%0d want=%0d", k, dv, exp_dv); end
            total++; if (neg !== exp_neg) begin bad++; $display("FAIL commit_neg k=%0d got=%b want=%b", k, neg, exp_neg); end
            total++; if (dec !== exp_dec) begin bad++; $display("FAIL commit_dec k=%0d got=%b want=%b", k, dec, exp_dec); end
            total++; if (ld.load_ready !== exp_rdy) begin bad++; $display("FAIL commit_ready k=%0d got=%b want=%b", k, ld.load_ready, exp_rdy); end
            total++; if (fd !== exp_fd) begin bad++; $display("FAIL commit_frame_done k=%0d got=%b want=%b", k, fd, exp_fd); end
            if (k == 7) begin
                ld.value_in = 6'd17; ld.negative_in = 1'b0; ld.is_dec_in = 1'b0; ld.load_valid = 1'b1;
            end else if (k == 8) begin
                ld.value_in = 6'd5; ld.negative_in = 1'b1; ld.is_dec_in = 1'b0;
            end else if (k == 25) begin
                ld.load_valid = 1'b0;
            end
        end
        enable = 1'b0;
        step();
        step();
    endtask

    task automatic test_disable();
        logic [3:0] exp_d;
        enable = 1'b1;
        for (int unsigned k = 0; k <= 13; k++) begin
            step();
            exp_d = ((k % 6) < 4) ? sel(k / 6) : 4'b1111;
            total++; if (digit !== exp_d) begin bad++; $display("FAIL dis_scan k=%0d got=%b want=%b", k, digit, exp_d); end
        end
        enable = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            step();
            total++; if (digit !== 4'b1111) begin bad++; $display("FAIL dis_dark k=%0d got=%b want=1111", k, digit); end
            total++; if (fd !== 1'b0) begin bad++; $display("FAIL dis_frame_done k=%0d got=%b want=0", k, fd); end
        end
        enable = 1'b1;
        for (int unsigned k = 0; k < 6; k++) begin
            step();
            exp_d = (k < 4) ? 4'b1110 : 4'b1111;
            total++; if (digit !== exp_d) begin bad++; $display("FAIL dis_restart k=%0d got=%b want=%b", k, digit, exp_d); end
            total++; if (fd !== 1'b0) begin bad++; $display("FAIL dis_restart_fd k=%0d got=%b want=0", k, fd); end
        end
        enable = 1'b0;
        step();
        step();
    endtask

    task automatic test_no_blank();
        logic [3:0] exp_d;
        logic       exp_fd;
        en0 = 1'b1;
        for (int unsigned k = 0; k <= 32; k++) begin
            step();
            exp_d  = sel((k % 16) / 4);
            exp_fd = (k == 16) || (k == 32);
            total++; if (digit0 !== exp_d) begin bad++; $display("FAIL noblank_digit k=%0d got=%b want=%b", k, digit0, exp_d); end
            total++; if (fd0 !== exp_fd) begin bad++; $display("FAIL noblank_fd k=%0d got=%b want=%b", k, fd0, exp_fd); end
        end
        total++; if ({dv0, neg0, dec0, ld0.load_ready} !== 9'b000000_001) begin
            bad++; $display("FAIL noblank_load_side got=%b want=000000001", {dv0, neg0, dec0, ld0.load_ready});
        end
        en0 = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        enable = 1'b1;
        for (int unsigned k = 0; k <= 4; k++) begin
            step();
            if (k == 1) begin
                ld.value_in = 6'd33; ld.negative_in = 1'b1; ld.is_dec_in = 1'b1; ld.load_valid = 1'b1;
            end else if (k == 2) begin
                total++; if (ld.load_ready !== 1'b0) begin bad++; $display("FAIL rstmid_accept got=%b want=0", ld.load_ready); end
                ld.load_valid = 1'b0;
            end
        end
        total++; if (digit !== 4'b1111) begin bad++; $display("FAIL rstmid_blank got=%b want=1111", digit); end
        total++; if (dv !== 6'd5) begin bad++; $display("FAIL rstmid_old_value got=%0d want=5", dv); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (digit !== 4'b1111) begin bad++; $display("FAIL rstmid_digit got=%b want=1111", digit); end
        total++; if (dv !== 6'd0) begin bad++; $display("FAIL rstmid_value got=%0d want=0", dv); end
        total++; if ({neg, dec, fd} !== 3'b000) begin bad++; $display("FAIL rstmid_flags got=%b want=000", {neg, dec, fd}); end
        total++; if (ld.load_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", ld.load_ready); end
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            step();
            total++; if (dv !== 6'd0) begin bad++; $display("FAIL rstmid_discard k=%0d got=%0d want=0", k, dv); end
            total++; if (ld.load_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready_after k=%0d got=%b want=1", k, ld.load_ready); end
            total++; if (digit !== 4'b1111) begin bad++; $display("FAIL rstmid_dark k=%0d got=%b want=1111", k, digit); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_idle_load();
        test_frame_commit();
        test_disable();
        test_no_blank();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
